// File: rtl/clock_pkg.sv
// Shared definitions for the century clock counters: BCD constants,
// default mode codes, BCD increment/decrement and the month-length table.
package clock_pkg;

   localparam logic [7:0] BCD_01 = 8'h01;
   localparam logic [7:0] BCD_12 = 8'h12;
   localparam logic [7:0] BCD_23 = 8'h23;
   localparam logic [7:0] BCD_28 = 8'h28;
   localparam logic [7:0] BCD_29 = 8'h29;
   localparam logic [7:0] BCD_30 = 8'h30;
   localparam logic [7:0] BCD_31 = 8'h31;
   localparam logic [7:0] BCD_59 = 8'h59;

   localparam logic [2:0] MODE_SET_NGAY_DEF  = 3'b011;
   localparam logic [2:0] MODE_SET_THANG_DEF = 3'b100;

   function automatic logic [7:0] bcd_plus1(input logic [7:0] v);
      if (v[3:0] >= 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_minus1(input logic [7:0] v);
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic [7:0] max_ngay(input logic [7:0] thang, input logic nam_nhuan);
      case (thang)
         8'h02:                      return nam_nhuan ? BCD_29 : BCD_28;
         8'h04, 8'h06, 8'h09, 8'h11: return BCD_30;
         default:                    return BCD_31;
      endcase
   endfunction

endpackage

// File: rtl/btn_repeat.sv
// Active-low button to one-cycle step: fires on the press edge, then every
// cycle once the button has been held REPEAT_DLY further cycles.
module btn_repeat #(
   parameter int REPEAT_DLY = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn_n,
   input  logic i_inhibit,
   output logic o_step
);

   localparam logic [4:0] CNT_MAX = 5'(REPEAT_DLY + 1);

   logic       r_hist;
   logic [4:0] r_cnt;
   logic       w_pressed;

   assign w_pressed = ~i_btn_n & ~i_inhibit;

   // The step is combinational so a press sampled at an edge acts at that edge.
   assign o_step = w_pressed & (~r_hist | (r_cnt == CNT_MAX));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hist <= 1'b0;
         r_cnt  <= 5'd0;
      end else if (!w_pressed) begin
         r_hist <= 1'b0;
         r_cnt  <= 5'd0;
      end else begin
         r_hist <= 1'b1;
         if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 5'd1;
      end
   end

endmodule

// File: rtl/dem_ngay_thang.sv
// Day/month BCD calendar counter: advances at 23:59:59 with leap-aware month
// lengths, pulses carry_nam on Dec->Jan, and supports button setting.
module dem_ngay_thang
   import clock_pkg::*;
#(
   parameter logic [2:0] MODE_SET_NGAY  = MODE_SET_NGAY_DEF,
   parameter logic [2:0] MODE_SET_THANG = MODE_SET_THANG_DEF,
   parameter int         REPEAT_DLY     = 2
) (
   input  logic       clk_1Hz,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [2:0] mode,
   input  logic [7:0] giay,
   input  logic [7:0] phut,
   input  logic [7:0] gio,
   input  logic       nam_nhuan,
   output logic [7:0] ngay,
   output logic [7:0] thang,
   output logic       carry_nam
);

   logic [7:0] r_ngay;
   logic [7:0] r_thang;
   logic       r_carry;

   logic       w_both;
   logic       w_step_up;
   logic       w_step_down;
   logic       w_set_ngay;
   logic       w_set_thang;
   logic       w_tick;
   logic [7:0] w_max;
   logic [7:0] w_thang_next;
   logic [7:0] w_max_next;

   assign w_both      = ~btn_up & ~btn_down;
   assign w_set_ngay  = (~mode == MODE_SET_NGAY);
   assign w_set_thang = (~mode == MODE_SET_THANG);
   assign w_tick      = (giay == BCD_59) && (phut == BCD_59) && (gio == BCD_23);
   assign w_max       = max_ngay(r_thang, nam_nhuan);

   btn_repeat #(.REPEAT_DLY(REPEAT_DLY)) u_rep_up (
      .clk       (clk_1Hz),
      .rst_n     (rst_n),
      .i_btn_n   (btn_up),
      .i_inhibit (w_both),
      .o_step    (w_step_up)
   );

   btn_repeat #(.REPEAT_DLY(REPEAT_DLY)) u_rep_down (
      .clk       (clk_1Hz),
      .rst_n     (rst_n),
      .i_btn_n   (btn_down),
      .i_inhibit (w_both),
      .o_step    (w_step_down)
   );

   // Month after a set-mode step, and its length for clamping the day.
   always_comb begin
      w_thang_next = r_thang;
      if (w_step_up)
         w_thang_next = (r_thang >= BCD_12) ? BCD_01 : bcd_plus1(r_thang);
      else if (w_step_down)
         w_thang_next = (r_thang <= BCD_01) ? BCD_12 : bcd_minus1(r_thang);
      w_max_next = max_ngay(w_thang_next, nam_nhuan);
   end

   always_ff @(posedge clk_1Hz) begin
      if (!rst_n) begin
         r_ngay  <= BCD_01;
         r_thang <= BCD_01;
         r_carry <= 1'b0;
      end else begin
         r_carry <= 1'b0;
         if (w_set_ngay) begin
            if (w_step_up)
               r_ngay <= (r_ngay >= w_max) ? BCD_01 : bcd_plus1(r_ngay);
            else if (w_step_down)
               r_ngay <= (r_ngay <= BCD_01 || r_ngay > w_max) ? w_max : bcd_minus1(r_ngay);
            else if (r_ngay > w_max)
               r_ngay <= w_max;
         end else if (w_set_thang) begin
            if (w_step_up || w_step_down) begin
               r_thang <= w_thang_next;
               r_ngay  <= (r_ngay > w_max_next) ? w_max_next : r_ngay;
            end else if (r_ngay > w_max) begin
               r_ngay <= w_max;
            end
         end else if (w_tick) begin
            if (r_ngay >= w_max) begin
               r_ngay <= BCD_01;
               if (r_thang >= BCD_12) begin
                  r_thang <= BCD_01;
                  r_carry <= 1'b1;
               end else begin
                  r_thang <= bcd_plus1(r_thang);
               end
            end else begin
               r_ngay <= bcd_plus1(r_ngay);
            end
         end else if (r_ngay > w_max) begin
            // Leap year cleared while sitting on 29 Feb.
            r_ngay <= w_max;
         end
      end
   end

   assign ngay      = r_ngay;
   assign thang     = r_thang;
   assign carry_nam = r_carry;

endmodule

// File: tb/tb_dem_ngay_thang.sv
// Directed bench for dem_ngay_thang: rollover, leap handling, set modes,
// auto-repeat timing and reset behaviour with hand-computed expectations.
module tb_dem_ngay_thang;

   localparam logic [2:0] M_RUN   = 3'b111;
   localparam logic [2:0] M_NGAY  = 3'b100;
   localparam logic [2:0] M_THANG = 3'b011;

   logic       clk_1Hz = 1'b0;
   logic       rst_n;
   logic       btn_up;
   logic       btn_down;
   logic [2:0] mode;
   logic [7:0] giay;
   logic [7:0] phut;
   logic [7:0] gio;
   logic       nam_nhuan;
   logic [7:0] ngay;
   logic [7:0] thang;
   logic       carry_nam;

   int total = 0;
   int bad   = 0;

   dem_ngay_thang #(
      .MODE_SET_NGAY  (3'b011),
      .MODE_SET_THANG (3'b100),
      .REPEAT_DLY     (2)
   ) dut (
      .clk_1Hz   (clk_1Hz),
      .rst_n     (rst_n),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .mode      (mode),
      .giay      (giay),
      .phut      (phut),
      .gio       (gio),
      .nam_nhuan (nam_nhuan),
      .ngay      (ngay),
      .thang     (thang),
      .carry_nam (carry_nam)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   // Advance one active edge, then settle away from it before sampling.
   task automatic step_edge();
      @(posedge clk_1Hz);
      #1;
   endtask

   task automatic applyStimulus(input logic tick);
      giay = tick ? 8'h59 : 8'h00;
      phut = tick ? 8'h59 : 8'h00;
      gio  = tick ? 8'h23 : 8'h00;
   endtask

   // One press of one edge followed by a release edge.
   task automatic press_btn(input bit up, input int n);
      for (int i = 0; i < n; i++) begin
         if (up) btn_up = 1'b0; else btn_down = 1'b0;
         step_edge();
         btn_up   = 1'b1;
         btn_down = 1'b1;
         step_edge();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step_edge();
      step_edge();
      total++; if (ngay !== 8'h01) begin bad++; $display("[TB] FAIL reset_ngay got=%h want=01", ngay); end
      total++; if (thang !== 8'h01) begin bad++; $display("[TB] FAIL reset_thang got=%h want=01", thang); end
      total++; if (carry_nam !== 1'b0) begin bad++; $display("[TB] FAIL reset_carry got=%b want=0", carry_nam); end
      rst_n = 1'b1;
      step_edge();
   endtask

   task automatic test_year_rollover();
      mode = M_THANG;
      press_btn(0, 1);
      total++; if (thang !== 8'h12) begin bad++; $display("[TB] FAIL set_thang_wrap_down got=%h want=12", thang); end
      mode = M_NGAY;
      press_btn(0, 1);
      total++; if (ngay !== 8'h31) begin bad++; $display("[TB] FAIL set_ngay_wrap_down got=%h want=31", ngay); end
      mode = M_RUN;
      applyStimulus(1'b1);
      step_edge();
      applyStimulus(1'b0);
      total++; if (ngay !== 8'h01) begin bad++; $display("[TB] FAIL roll_ngay got=%h want=01", ngay); end
      total++; if (thang !== 8'h01) begin bad++; $display("[TB] FAIL roll_thang got=%h want=01", thang); end
      total++; if (carry_nam !== 1'b1) begin bad++; $display("[TB] FAIL roll_carry_hi got=%b want=1", carry_nam); end
      step_edge();
      total++; if (carry_nam !== 1'b0) begin bad++; $display("[TB] FAIL roll_carry_lo got=%b want=0", carry_nam); end
      total++; if (ngay !== 8'h01) begin bad++; $display("[TB] FAIL roll_ngay_hold got=%h want=01", ngay); end
   endtask

   task automatic test_february();
      nam_nhuan = 1'b1;
      mode = M_THANG;
      press_btn(1, 1);
      mode = M_NGAY;
      press_btn(0, 1);
      total++; if (ngay !== 8'h29 || thang !== 8'h02) begin bad++; $display("[TB] FAIL leap_feb_max got=%h/%h want=29/02", ngay, thang); end
      mode = M_RUN;
      applyStimulus(1'b1);
      step_edge();
      applyStimulus(1'b0);
      total++; if (ngay !== 8'h01 || thang !== 8'h03) begin bad++; $display("[TB] FAIL leap_feb_tick got=%h/%h want=01/03", ngay, thang); end
      total++; if (carry_nam !== 1'b0) begin bad++; $display("[TB] FAIL leap_feb_carry got=%b want=0", carry_nam); end
      // Back to 29 Feb, then lose the leap year: the day must clamp to 28.
      mode = M_THANG;
      press_btn(0, 1);
      mode = M_NGAY;
      press_btn(0, 1);
      mode = M_RUN;
      nam_nhuan = 1'b0;
      step_edge();
      total++; if (ngay !== 8'h28 || thang !== 8'h02) begin bad++; $display("[TB] FAIL leap_guard got=%h/%h want=28/02", ngay, thang); end
      applyStimulus(1'b1);
      step_edge();
      applyStimulus(1'b0);
      total++; if (ngay !== 8'h01 || thang !== 8'h03) begin bad++; $display("[TB] FAIL feb28_tick got=%h/%h want=01/03", ngay, thang); end
   endtask

   task automatic test_month_clamp();
      mode = M_THANG;
      press_btn(0, 2);
      mode = M_NGAY;
      press_btn(0, 1);
      total++; if (ngay !== 8'h31 || thang !== 8'h01) begin bad++; $display("[TB] FAIL clamp_setup got=%h/%h want=31/01", ngay, thang); end
      mode = M_THANG;
      press_btn(1, 1);
      total++; if (ngay !== 8'h28 || thang !== 8'h02) begin bad++; $display("[TB] FAIL clamp_up got=%h/%h want=28/02", ngay, thang); end
      press_btn(0, 1);
      total++; if (ngay !== 8'h28 || thang !== 8'h01) begin bad++; $display("[TB] FAIL clamp_down got=%h/%h want=28/01", ngay, thang); end
   endtask

   task automatic test_auto_repeat();
      logic [7:0] exp_a [6] = '{8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h05};
      logic [7:0] exp_b [4] = '{8'h30, 8'h30, 8'h30, 8'h01};
      mode = M_THANG;
      press_btn(1, 3);
      mode = M_NGAY;
      press_btn(1, 3);
      total++; if (ngay !== 8'h01 || thang !== 8'h04) begin bad++; $display("[TB] FAIL rep_setup got=%h/%h want=01/04", ngay, thang); end
      btn_up = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step_edge();
         total++; if (ngay !== exp_a[i]) begin bad++; $display("[TB] FAIL rep_hold_%0d got=%h want=%h", i, ngay, exp_a[i]); end
      end
      btn_up = 1'b1;
      step_edge();
      press_btn(0, 6);
      total++; if (ngay !== 8'h29) begin bad++; $display("[TB] FAIL rep_down_to29 got=%h want=29", ngay); end
      btn_up = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step_edge();
         total++; if (ngay !== exp_b[i]) begin bad++; $display("[TB] FAIL rep_wrap_%0d got=%h want=%h", i, ngay, exp_b[i]); end
      end
      btn_up = 1'b1;
      step_edge();
   endtask

   task automatic test_inhibit();
      mode = M_NGAY;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      for (int i = 0; i < 3; i++) step_edge();
      total++; if (ngay !== 8'h01) begin bad++; $display("[TB] FAIL both_pressed got=%h want=01", ngay); end
      btn_up   = 1'b1;
      btn_down = 1'b1;
      step_edge();
      applyStimulus(1'b1);
      step_edge();
      applyStimulus(1'b0);
      total++; if (ngay !== 8'h01 || thang !== 8'h04) begin bad++; $display("[TB] FAIL tick_in_set got=%h/%h want=01/04", ngay, thang); end
   endtask

   task automatic test_reset_mid_repeat();
      mode = M_NGAY;
      press_btn(1, 15);
      btn_up = 1'b0;
      step_edge();
      total++; if (ngay !== 8'h17) begin bad++; $display("[TB] FAIL mid_press got=%h want=17", ngay); end
      step_edge();
      rst_n = 1'b0;
      step_edge();
      total++; if (ngay !== 8'h01 || thang !== 8'h01) begin bad++; $display("[TB] FAIL mid_reset got=%h/%h want=01/01", ngay, thang); end
      rst_n  = 1'b1;
      btn_up = 1'b1;
      step_edge();
      step_edge();
      total++; if (ngay !== 8'h01) begin bad++; $display("[TB] FAIL post_reset_idle got=%h want=01", ngay); end
      btn_up = 1'b0;
      step_edge();
      total++; if (ngay !== 8'h02) begin bad++; $display("[TB] FAIL post_reset_press got=%h want=02", ngay); end
      step_edge();
      step_edge();
      total++; if (ngay !== 8'h02) begin bad++; $display("[TB] FAIL post_reset_delay got=%h want=02", ngay); end
      step_edge();
      total++; if (ngay !== 8'h03) begin bad++; $display("[TB] FAIL post_reset_repeat got=%h want=03", ngay); end
      btn_up = 1'b1;
      step_edge();
   endtask

   initial begin
      rst_n     = 1'b0;
      btn_up    = 1'b1;
      btn_down  = 1'b1;
      mode      = M_RUN;
      nam_nhuan = 1'b0;
      applyStimulus(1'b0);
      test_reset();
      test_year_rollover();
      test_february();
      test_month_clamp();
      test_auto_repeat();
      test_inhibit();
      test_reset_mid_repeat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
